// File: rtl/sdram_test_result_counter.sv
// ---------------------------------------------------------------------------
// sdram_test_result_counter
//
// Collects per-word compare results from the SDRAM test engine and feeds the
// six-digit seven-segment decoder.
//   * word_cnt counts every compared word. err_cnt counts mismatching words.
//     Both counters saturate at MAX_COUNT.
//   * err_flag is sticky. It is set by the first error seen after reset or
//     clear.
//   * The displayed value (num) is a snapshot of the page-selected value. It
//     is refreshed every REFRESH_CYCLES clocks, on a page change, or on clear.
//
// Optional feature (compile-time macro SDRAM_RESULT_FIRST_ERR_ADDR_EN):
//   When the macro is defined, the address of the first error is captured
//   and shown on page 2, giving the page sequence 0->1->2->0.
//   When it is undefined, there is no capture register and the page
//   sequence is 0->1->0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   clear        synchronous clear of counters, flag and captured address
//   result_valid one-cycle strobe, one word compared
//   result_error mismatch indication, qualified by result_valid
//   result_addr  word address of the result, qualified by result_valid
//   page_next    one-cycle pulse that advances the display page
//   num          20-bit binary value for the display decoder
//   page         current page (0 words, 1 errors, 2 first error address)
//   err_flag     sticky error flag
//   sat          registered "either counter at MAX_COUNT"
// ---------------------------------------------------------------------------
module sdram_test_result_counter #(
   parameter int ADDR_W         = 24,
   parameter int MAX_COUNT      = 999999,
   parameter int REFRESH_CYCLES = 5000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              result_valid,
   input  logic              result_error,
   input  logic [ADDR_W-1:0] result_addr,
   input  logic              page_next,
   output logic [19:0]       num,
   output logic [1:0]        page,
   output logic              err_flag,
   output logic              sat
);

   localparam int               REF_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
   localparam logic [19:0]      MAX_VAL  = 20'(MAX_COUNT);

   logic [19:0]      word_cnt_reg;
   logic [19:0]      err_cnt_reg;
   logic             err_flag_reg;
   logic             sat_reg;
   logic [1:0]       page_reg;
   logic [19:0]      num_reg;
   logic [REF_W-1:0] refresh_cnt_reg;
   logic             load_pending_reg;   // page changed last cycle: reload num now

   logic             tick;
   logic [1:0]       page_next_val;
   logic [19:0]      addr_view;
   logic [19:0]      sel_val;
   logic             first_error;

   assign tick        = (refresh_cnt_reg == REF_LAST);
   assign first_error = result_valid && result_error && !err_flag_reg;

`ifdef SDRAM_RESULT_FIRST_ERR_ADDR_EN
   logic [ADDR_W-1:0] first_addr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         first_addr_reg <= '0;
      end else if (clear) begin
         first_addr_reg <= '0;
      end else if (first_error) begin
         first_addr_reg <= result_addr;
      end
   end

   // Page 2 shows the low 20 address bits. A narrower address is zero-extended.
   generate
      if (ADDR_W >= 20) begin : g_addr_trunc
         assign addr_view = first_addr_reg[19:0];
      end else begin : g_addr_ext
         assign addr_view = {{(20-ADDR_W){1'b0}}, first_addr_reg};
      end
   endgenerate

   always_comb begin
      page_next_val = (page_reg == 2'd2) ? 2'd0 : page_reg + 2'd1;
   end
`else
   // The address is only needed by the capture register.
   logic unused_addr;
   assign unused_addr = ^result_addr;
   assign addr_view   = '0;

   always_comb begin
      page_next_val = (page_reg == 2'd0) ? 2'd1 : 2'd0;
   end
`endif

   always_comb begin
      sel_val = '0;
      case (page_reg)
         2'd0:    sel_val = word_cnt_reg;
         2'd1:    sel_val = err_cnt_reg;
         2'd2:    sel_val = addr_view;
         default: sel_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt_reg     <= '0;
         err_cnt_reg      <= '0;
         err_flag_reg     <= 1'b0;
         sat_reg          <= 1'b0;
         page_reg         <= 2'd0;
         num_reg          <= '0;
         refresh_cnt_reg  <= '0;
         load_pending_reg <= 1'b0;
      end else begin
         // sat follows the counter registers with one cycle of delay.
         sat_reg <= (word_cnt_reg == MAX_VAL) | (err_cnt_reg == MAX_VAL);

         if (page_next) begin
            page_reg <= page_next_val;
         end
         load_pending_reg <= page_next;

         if (clear || page_next || tick) begin
            refresh_cnt_reg <= '0;
         end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
         end

         // A page change overrides a coincident tick. The snapshot is taken
         // on the following cycle, from the new page.
         if (clear) begin
            num_reg <= '0;
         end else if (!page_next && (load_pending_reg || tick)) begin
            num_reg <= sel_val;
         end

         if (clear) begin
            word_cnt_reg <= '0;
            err_cnt_reg  <= '0;
            err_flag_reg <= 1'b0;
         end else if (result_valid) begin
            if (word_cnt_reg != MAX_VAL) begin
               word_cnt_reg <= word_cnt_reg + 20'd1;
            end
            if (result_error) begin
               if (err_cnt_reg != MAX_VAL) begin
                  err_cnt_reg <= err_cnt_reg + 20'd1;
               end
               err_flag_reg <= 1'b1;
            end
         end
      end
   end

   assign num      = num_reg;
   assign page     = page_reg;
   assign err_flag = err_flag_reg;
   assign sat      = sat_reg;

endmodule

// File: tb/tb_sdram_test_result_counter.sv
// ---------------------------------------------------------------------------
// Bench for sdram_test_result_counter. It drives two instances with the same
// inputs:
//   * instance a uses MAX_COUNT=999999.
//   * instance b uses MAX_COUNT=5.
// Both instances use REFRESH_CYCLES=4.
// A cycle model predicts the expected outputs of both instances.
// ---------------------------------------------------------------------------
module tb_sdram_test_result_counter;
   localparam int R      = 4;
   localparam int ADDR_W = 24;

   logic              clk = 1'b0;
   logic              rst, clear, result_valid, result_error, page_next;
   logic [ADDR_W-1:0] result_addr;
   logic [19:0]       num_a, num_b;
   logic [1:0]        page_a, page_b;
   logic              flag_a, flag_b, sat_a, sat_b;

   always #5 clk = ~clk;

   sdram_test_result_counter #(.ADDR_W(ADDR_W), .MAX_COUNT(999999), .REFRESH_CYCLES(R)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .result_valid(result_valid),
      .result_error(result_error), .result_addr(result_addr), .page_next(page_next),
      .num(num_a), .page(page_a), .err_flag(flag_a), .sat(sat_a));

   sdram_test_result_counter #(.ADDR_W(ADDR_W), .MAX_COUNT(5), .REFRESH_CYCLES(R)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .result_valid(result_valid),
      .result_error(result_error), .result_addr(result_addr), .page_next(page_next),
      .num(num_b), .page(page_b), .err_flag(flag_b), .sat(sat_b));

   int checks = 0;
   int passed = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // ---------------- behavioural model ----------------
   int maxv[2] = '{999999, 5};
   int m_w[2], m_e[2], m_fa[2], m_num[2], m_sat[2], m_flag[2];
   int m_page, m_phase, m_newpage, m_shown;
   bit m_load, m_tick;
   bit model_live = 1'b0;

   function automatic int next_page(int p);
`ifdef SDRAM_RESULT_FIRST_ERR_ADDR_EN
      return (p + 1) % 3;
`else
      return (p + 1) % 2;
`endif
   endfunction

   function automatic int page_value(int k, int p);
      if (p == 0) return m_w[k];
      if (p == 1) return m_e[k];
      return m_fa[k] & 'hFFFFF;
   endfunction

   function automatic int sat_min(int a, int b);
      return (a < b) ? a : b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_w[k] = 0; m_e[k] = 0; m_fa[k] = 0; m_num[k] = 0; m_sat[k] = 0; m_flag[k] = 0;
         end
         m_page = 0; m_phase = 0; m_load = 0; model_live = 1'b1;
      end else begin
         m_tick    = (m_phase == R - 1);
         m_newpage = page_next ? next_page(m_page) : m_page;
         for (int k = 0; k < 2; k++) begin
            m_shown  = page_value(k, m_page);
            m_sat[k] = (m_w[k] == maxv[k] || m_e[k] == maxv[k]) ? 1 : 0;
            if (clear) m_num[k] = 0;
            else if (!page_next && (m_load || m_tick)) m_num[k] = m_shown;
            if (clear) begin
               m_w[k] = 0; m_e[k] = 0; m_fa[k] = 0; m_flag[k] = 0;
            end else if (result_valid) begin
               m_w[k] = sat_min(m_w[k] + 1, maxv[k]);
               if (result_error) begin
                  m_e[k] = sat_min(m_e[k] + 1, maxv[k]);
                  if (m_flag[k] == 0) begin
                     m_flag[k] = 1;
                     m_fa[k]   = int'(result_addr);
                  end
               end
            end
         end
         m_load  = page_next;
         m_phase = (clear || page_next || m_tick) ? 0 : m_phase + 1;
         m_page  = m_newpage;
      end
   end

   // Compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (model_live) begin
         chk("num_a",  int'(num_a),  m_num[0]);
         chk("num_b",  int'(num_b),  m_num[1]);
         chk("page_a", int'(page_a), m_page);
         chk("page_b", int'(page_b), m_page);
         chk("flag_a", int'(flag_a), m_flag[0]);
         chk("flag_b", int'(flag_b), m_flag[1]);
         chk("sat_a",  int'(sat_a),  m_sat[0]);
         chk("sat_b",  int'(sat_b),  m_sat[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(bit v, bit e, int addr, bit pn, bit clr);
      result_valid = v; result_error = e; result_addr = ADDR_W'(addr);
      page_next = pn; clear = clr;
      @(posedge clk); #1;
      result_valid = 0; result_error = 0; page_next = 0; clear = 0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;
      rst = 1; clear = 0; result_valid = 0; result_error = 0; page_next = 0; result_addr = '0;
      repeat (2) @(posedge clk);
      #1; rst = 0;
      chk("rst_num",  int'(num_a), 0);
      chk("rst_page", int'(page_a), 0);
      chk("rst_flag", int'(flag_a), 0);
      chk("rst_sat",  int'(sat_b), 0);

      // Send 10 words with 3 errors, then wait for a tick.
      for (int i = 0; i < 10; i++) begin
         send(1'b1, (i == 2 || i == 5 || i == 8), (i == 2) ? 'hABCDE : (i == 5) ? 'h12345 : (i == 8) ? 'h55555 : i * 16, 1'b0, 1'b0);
      end
      idle(5);
      chk("words_num_a", int'(num_a), 10);
      chk("words_num_b", int'(num_b), 5);
      chk("sat_b_words", int'(sat_b), 1);
      chk("sat_a_words", int'(sat_a), 0);
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("pg_hold_num", int'(num_a), 10);
      chk("pg1_page", int'(page_a), 1);
      idle(1);
      chk("pg1_num", int'(num_a), 3);
      chk("pg1_flag", int'(flag_a), 1);

`ifdef SDRAM_RESULT_FIRST_ERR_ADDR_EN
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      idle(1);
      chk("pg2_page", int'(page_a), 2);
      chk("pg2_num",  int'(num_a), 'hABCDE);
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("pg_wrap", int'(page_a), 0);
`else
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("pg_seq0", int'(page_a), 0);
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("pg_seq1", int'(page_a), 1);
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("pg_seq0b", int'(page_a), 0);
`endif
      idle(1);
      chk("pg0_num", int'(num_a), 10);

      // Saturation at MAX_COUNT=5 with 8 errors, then clear.
      send(1'b0, 1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 'h100 + i, 1'b0, 1'b0);
      idle(5);
      chk("satur_num_b", int'(num_b), 5);
      chk("satur_sat_b", int'(sat_b), 1);
      chk("satur_num_a", int'(num_a), 8);
      send(1'b0, 1'b0, 0, 1'b0, 1'b1);
      chk("clr_num_b",  int'(num_b), 0);
      chk("clr_flag_b", int'(flag_b), 0);
      idle(1);
      chk("clr_sat_b", int'(sat_b), 0);

      // A page_next that coincides with a tick, with err_cnt=7.
      for (int i = 0; i < 10; i++) send(1'b1, (i < 7), 'h200 + i, 1'b0, 1'b0);
      idle(5);
      chk("pre_tick_num", int'(num_a), 10);
      guard = 0;
      while (m_phase != R - 1 && guard < 10) begin
         idle(1);
         guard++;
      end
      chk("tick_align", guard < 10 ? 1 : 0, 1);
      send(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("tick_pg_page", int'(page_a), 1);
      chk("tick_pg_hold", int'(num_a), 10);
      idle(1);
      chk("tick_pg_num_a", int'(num_a), 7);
      chk("tick_pg_num_b", int'(num_b), 5);

      // A clear that coincides with a valid error discards the result.
      send(1'b1, 1'b1, 'h777, 1'b0, 1'b1);
      chk("clr_res_num", int'(num_a), 0);
      idle(5);
      chk("clr_res_num2", int'(num_a), 0);
      chk("clr_res_flag", int'(flag_a), 0);

      // Assert rst in the middle of the run.
      for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 'h300 + i, 1'b0, 1'b0);
      idle(5);
      chk("mid_num", int'(num_a), 3);
      rst = 1;
      @(posedge clk); #1;
      chk("mrst_num",  int'(num_a), 0);
      chk("mrst_page", int'(page_a), 0);
      chk("mrst_flag", int'(flag_a), 0);
      chk("mrst_sat",  int'(sat_b), 0);
      rst = 0;
      idle(2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
